// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals: requests from bus-register ports, grant/status back.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [OW-1:0]    owner;
  logic             busy;
  logic             turn;

  modport master (output req, input gnt, owner, busy, turn);
  modport slave  (input req, output gnt, owner, busy, turn);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared tristate data bus: one driver at a time,
// bounded tenure under contention, one undriven turnaround cycle between owners.
module bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  bus_arbiter_if.slave  bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t           state;
  logic [OW-1:0]    last;
  logic [HW-1:0]    hold_cnt;

  logic             found;
  logic [OW-1:0]    win;
  logic [N_REQ-1:0] win_oh;
  logic             others;
  int unsigned      cand;
  logic [OW-1:0]    cand_idx;

  // Search starts one past the last winner and wraps, so the last winner is checked last.
  always_comb begin
    found    = 1'b0;
    win      = last;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand     = (32'(last) + i) % N_REQ;
      cand_idx = OW'(cand);
      if (!found && bus.req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
    others      = |(bus.req & ~bus.gnt);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      last      <= OW'(N_REQ - 1);
      hold_cnt  <= '0;
      bus.gnt   <= '0;
      bus.owner <= '0;
      bus.busy  <= 1'b0;
      bus.turn  <= 1'b0;
    end else begin
      case (state)
        IDLE, TURN: begin
          bus.turn <= 1'b0;
          if (found) begin
            state     <= GRANT;
            bus.gnt   <= win_oh;
            bus.owner <= win;
            last      <= win;
            bus.busy  <= 1'b1;
            hold_cnt  <= HW'(1);
          end else begin
            state    <= IDLE;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
          end
        end
        GRANT: begin
          if (!bus.req[bus.owner] || (hold_cnt == HW'(MAX_HOLD) && others)) begin
            state    <= TURN;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            bus.turn <= 1'b1;
          end else if (hold_cnt != HW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          bus.turn <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: tenure-level model checked every cycle, plus directed
// sequences with literal expected grants.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  bus_arbiter_if #(.N_REQ(N)) bus ();
  bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the bus (-1 none), how long they've held it, who won last.
  int m_own   = -1;
  int m_last  = N - 1;
  int m_owner = 0;
  int m_run   = 0;
  bit m_turn  = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int d = 1; d <= N; d++) begin
      if (r[(from + d) % N]) return (from + d) % N;
    end
    return -1;
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_own <= -1; m_last <= N - 1; m_owner <= 0; m_run <= 0; m_turn <= 1'b0;
    end else if (m_own >= 0) begin
      if (!bus.req[m_own] || (m_run >= MH && (bus.req & ~(N'(1) << m_own)) != '0)) begin
        m_own  <= -1;
        m_turn <= 1'b1;
      end else begin
        m_run <= m_run + 1;
      end
    end else begin
      m_turn <= 1'b0;
      if (bus.req != '0) begin
        m_own   <= pick(bus.req, m_last);
        m_last  <= pick(bus.req, m_last);
        m_owner <= pick(bus.req, m_last);
        m_run   <= 1;
      end
    end
  end

  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] exp_gnt;
  always @(negedge Clock) begin
    exp_gnt = (m_own >= 0) ? (N'(1) << m_own) : '0;
    check("outputs{gnt,owner,busy,turn}", {bus.gnt, bus.owner, bus.busy, bus.turn},
          {exp_gnt, 2'(m_owner), (m_own >= 0), m_turn});
    check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    check("no_direct_switch", 32'(prev_gnt != '0 && bus.gnt != '0 && prev_gnt != bus.gnt), 32'd0);
    prev_gnt <= bus.gnt;
  end

  logic [N-1:0] seq [21] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                             4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                             4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                             4'b0001};

  initial begin
    bus.req = '1;
    repeat (3) begin
      @(negedge Clock);
      check("reset_gnt", bus.gnt, 0);
      check("reset_busy_turn", {bus.busy, bus.turn}, 0);
    end
    Resetn = 1'b1;

    // contention: 4-cycle tenures with one turnaround each, wrapping to 0
    for (int i = 0; i < 21; i++) begin
      @(negedge Clock);
      check("contention_gnt", bus.gnt, seq[i]);
      check("contention_turn", bus.turn, (seq[i] == '0));
    end
    check("contention_owner", bus.owner, 0);
    bus.req = '0;
    repeat (2) @(negedge Clock);
    check("drain_idle", {bus.gnt, bus.busy, bus.turn}, 0);

    // single requester keeps the bus past MAX_HOLD
    bus.req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("single_gnt", {bus.gnt, bus.turn}, {4'b0100, 1'b0});
    end
    bus.req = '0;
    @(negedge Clock);
    check("single_release_turn", {bus.gnt, bus.busy, bus.turn}, {4'b0000, 1'b0, 1'b1});
    @(negedge Clock);
    check("single_idle", {bus.gnt, bus.busy, bus.turn}, 0);
    check("single_owner", bus.owner, 2);

    // early release by owner 1 while requester 3 waits
    bus.req = 4'b0010;
    @(negedge Clock);
    check("early_gnt1", bus.gnt, 4'b0010);
    bus.req = 4'b1010;
    @(negedge Clock);
    check("early_gnt2", bus.gnt, 4'b0010);
    bus.req = 4'b1000;
    @(negedge Clock);
    check("early_turn", {bus.gnt, bus.turn}, {4'b0000, 1'b1});
    @(negedge Clock);
    check("early_next", {bus.gnt, bus.owner}, {4'b1000, 2'd3});
    bus.req = '0;
    repeat (3) @(negedge Clock);

    // reset while requester 2 holds the bus
    bus.req = 4'b0100;
    @(negedge Clock);
    check("midrst_pre", bus.gnt, 4'b0100);
    #2 Resetn = 1'b0;
    bus.req = '1;
    #1 check("midrst_async", {bus.gnt, bus.busy, bus.turn}, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    check("midrst_first", {bus.gnt, bus.owner}, {4'b0001, 2'd0});
    bus.req = '0;
    repeat (3) @(negedge Clock);

    // random stream with sticky requests
    repeat (5000) begin
      @(negedge Clock);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
    end
    @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
